id_ex_stage: RTL and testbench



---
 rtl/id_ex_stage_pkg.sv | 32 +++
 rtl/id_ex_stage_hazard_detect.sv | 39 +++
 rtl/id_ex_stage.sv | 151 +++++++++++++++
 tb/tb_id_ex_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU op encodings, forwarding selects,
// the zero-register constant and the register-dependency match helper.
package id_ex_stage_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [3:0] ALU_NOP  = 4'd0;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_NOR = 4'd5,
    ALU_XOR = 4'd6
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_NONE   = 2'b00,
    FWD_MEM_WB = 2'b01,
    FWD_EX_MEM = 2'b10
  } fwd_sel_e;

  // $0 is hardwired, so a write to it never creates a real dependency
  function automatic logic reg_match(input logic [4:0] r,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rt);
    return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational detection of hazards that forwarding cannot cover, and the
// number of stall cycles each one needs.
module id_ex_stage_hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  input  logic       uses_rt,
  input  logic       is_branch,
  input  logic [4:0] id_ex_rd,
  input  logic       id_ex_mem_read,
  input  logic [4:0] ex_mem_rd,
  input  logic       ex_mem_mem_read,
  output logic       hazard,
  output logic [1:0] need
);

  logic load_use_s;
  logic br_mem_s;

  // A branch right behind a load waits for the load to reach WB-forwardable data
  always_comb begin
    load_use_s = id_ex_mem_read && reg_match(id_ex_rd, if_id_rs, if_id_rt, uses_rt);
    br_mem_s   = is_branch && ex_mem_mem_read && reg_match(ex_mem_rd, if_id_rs, if_id_rt, uses_rt);
    hazard     = 1'b0;
    need       = 2'd0;
    if (load_use_s) begin
      hazard = 1'b1;
      need   = is_branch ? 2'd2 : 2'd1;
    end else if (br_mem_s) begin
      hazard = 1'b1;
      need   = 2'd1;
    end else begin
      hazard = 1'b0;
      need   = 2'd0;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use / load-branch stall sequencing,
// bubble insertion and a saturating stall counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        IF_ID_Rs,
  input  logic [4:0]        IF_ID_Rt,
  input  logic [4:0]        IF_ID_Rd,
  input  logic              id_uses_rt,
  input  logic              id_is_branch,
  input  logic              id_regWrite,
  input  logic              id_memRead,
  input  logic              id_memWrite,
  input  logic              id_memToReg,
  input  logic              id_aluSrc,
  input  logic              id_regDst,
  input  logic [3:0]        id_aluOp,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        EX_MEM_Rd,
  input  logic              EX_MEM_memRead,
  input  logic              flush,
  output logic [4:0]        ID_EX_Rs,
  output logic [4:0]        ID_EX_Rt,
  output logic [4:0]        ID_EX_Rd,
  output logic              ID_EX_regWrite,
  output logic              ID_EX_memRead,
  output logic              ID_EX_memWrite,
  output logic              ID_EX_memToReg,
  output logic              ID_EX_aluSrc,
  output logic [3:0]        ID_EX_aluOp,
  output logic [DATA_W-1:0] ID_EX_rs_data,
  output logic [DATA_W-1:0] ID_EX_rt_data,
  output logic [DATA_W-1:0] ID_EX_imm,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  stall_count
);

  logic       hazard_s;
  logic [1:0] need_s;
  logic [1:0] rem_r;
  logic [1:0] rem_nxt_s;
  logic       stall_s;

  id_ex_stage_hazard_detect u_hazard_detect (
    .if_id_rs        (IF_ID_Rs),
    .if_id_rt        (IF_ID_Rt),
    .uses_rt         (id_uses_rt),
    .is_branch       (id_is_branch),
    .id_ex_rd        (ID_EX_Rd),
    .id_ex_mem_read  (ID_EX_memRead),
    .ex_mem_rd       (EX_MEM_Rd),
    .ex_mem_mem_read (EX_MEM_memRead),
    .hazard          (hazard_s),
    .need            (need_s)
  );

  // Stall sequencer next state; detection is only consulted while idle (rem == 0)
  always_comb begin
    rem_nxt_s = rem_r;
    stall_s   = 1'b0;
    if (flush) begin
      rem_nxt_s = 2'd0;
      stall_s   = 1'b0;
    end else if (rem_r != 2'd0) begin
      rem_nxt_s = rem_r - 2'd1;
      stall_s   = 1'b1;
    end else if (hazard_s) begin
      rem_nxt_s = need_s - 2'd1;
      stall_s   = 1'b1;
    end else begin
      rem_nxt_s = 2'd0;
      stall_s   = 1'b0;
    end
  end

  assign pc_write    = !stall_s;
  assign if_id_write = !stall_s;

  // Remaining-stall register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r <= 2'd0;
    end else begin
      rem_r <= rem_nxt_s;
    end
  end

  // Pipeline register: flush zeroes everything, stall bubbles only the control bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID_EX_Rs       <= 5'd0;
      ID_EX_Rt       <= 5'd0;
      ID_EX_Rd       <= 5'd0;
      ID_EX_regWrite <= 1'b0;
      ID_EX_memRead  <= 1'b0;
      ID_EX_memWrite <= 1'b0;
      ID_EX_memToReg <= 1'b0;
      ID_EX_aluSrc   <= 1'b0;
      ID_EX_aluOp    <= ALU_NOP;
      ID_EX_rs_data  <= '0;
      ID_EX_rt_data  <= '0;
      ID_EX_imm      <= '0;
    end else if (flush) begin
      ID_EX_Rs       <= 5'd0;
      ID_EX_Rt       <= 5'd0;
      ID_EX_Rd       <= 5'd0;
      ID_EX_regWrite <= 1'b0;
      ID_EX_memRead  <= 1'b0;
      ID_EX_memWrite <= 1'b0;
      ID_EX_memToReg <= 1'b0;
      ID_EX_aluSrc   <= 1'b0;
      ID_EX_aluOp    <= ALU_NOP;
      ID_EX_rs_data  <= '0;
      ID_EX_rt_data  <= '0;
      ID_EX_imm      <= '0;
    end else begin
      ID_EX_Rs       <= IF_ID_Rs;
      ID_EX_Rt       <= IF_ID_Rt;
      ID_EX_Rd       <= id_regDst ? IF_ID_Rd : IF_ID_Rt;
      ID_EX_rs_data  <= id_rs_data;
      ID_EX_rt_data  <= id_rt_data;
      ID_EX_imm      <= id_imm;
      ID_EX_regWrite <= stall_s ? 1'b0 : id_regWrite;
      ID_EX_memRead  <= stall_s ? 1'b0 : id_memRead;
      ID_EX_memWrite <= stall_s ? 1'b0 : id_memWrite;
      ID_EX_memToReg <= stall_s ? 1'b0 : id_memToReg;
      ID_EX_aluSrc   <= stall_s ? 1'b0 : id_aluSrc;
      ID_EX_aluOp    <= stall_s ? ALU_NOP : id_aluOp;
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall_s && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_count <= stall_count;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a hand-derived vector table run through a
// scoreboard queue, plus reset-mid-stall and counter saturation sequences.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  IF_ID_Rs, IF_ID_Rt, IF_ID_Rd;
  logic        id_uses_rt, id_is_branch;
  logic        id_regWrite, id_memRead, id_memWrite, id_memToReg, id_aluSrc, id_regDst;
  logic [3:0]  id_aluOp;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  EX_MEM_Rd;
  logic        EX_MEM_memRead, flush;
  logic [4:0]  ID_EX_Rs, ID_EX_Rt, ID_EX_Rd;
  logic        ID_EX_regWrite, ID_EX_memRead, ID_EX_memWrite, ID_EX_memToReg, ID_EX_aluSrc;
  logic [3:0]  ID_EX_aluOp;
  logic [31:0] ID_EX_rs_data, ID_EX_rt_data, ID_EX_imm;
  logic        pc_write, if_id_write;
  logic [15:0] stall_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_Rd(IF_ID_Rd),
    .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
    .id_regWrite(id_regWrite), .id_memRead(id_memRead), .id_memWrite(id_memWrite),
    .id_memToReg(id_memToReg), .id_aluSrc(id_aluSrc), .id_regDst(id_regDst),
    .id_aluOp(id_aluOp), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_memRead(EX_MEM_memRead), .flush(flush),
    .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt), .ID_EX_Rd(ID_EX_Rd),
    .ID_EX_regWrite(ID_EX_regWrite), .ID_EX_memRead(ID_EX_memRead),
    .ID_EX_memWrite(ID_EX_memWrite), .ID_EX_memToReg(ID_EX_memToReg),
    .ID_EX_aluSrc(ID_EX_aluSrc), .ID_EX_aluOp(ID_EX_aluOp),
    .ID_EX_rs_data(ID_EX_rs_data), .ID_EX_rt_data(ID_EX_rt_data), .ID_EX_imm(ID_EX_imm),
    .pc_write(pc_write), .if_id_write(if_id_write), .stall_count(stall_count)
  );

  // ctl / e_ctl = {memWrite, memToReg, aluSrc}
  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic        uses_rt, is_br, rw, mr, rdst;
    logic [2:0]  ctl;
    logic [3:0]  op;
    logic [31:0] d;
    logic [4:0]  exrd;
    logic        exmr, fl;
    logic        e_pcw, e_rw, e_mr;
    logic [2:0]  e_ctl;
    logic [3:0]  e_op;
    logic [4:0]  e_rd;
    logic [31:0] e_d;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    logic        rw, mr;
    logic [2:0]  ctl;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] d, rtd, imm;
    logic [15:0] cnt;
  } exp_t;

  localparam int NV = 21;
  localparam logic [31:0] RT_MASK = 32'hA5A5_0000;
  vec_t vecs [NV];
  exp_t sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    IF_ID_Rs = v.rs; IF_ID_Rt = v.rt; IF_ID_Rd = v.rd;
    id_uses_rt = v.uses_rt; id_is_branch = v.is_br;
    id_regWrite = v.rw; id_memRead = v.mr; id_regDst = v.rdst;
    {id_memWrite, id_memToReg, id_aluSrc} = v.ctl;
    id_aluOp = v.op; id_rs_data = v.d; id_rt_data = v.d ^ RT_MASK; id_imm = v.d + 32'd7;
    EX_MEM_Rd = v.exrd; EX_MEM_memRead = v.exmr; flush = v.fl;
    #1;
    chk("pc_write", {31'd0, pc_write}, {31'd0, v.e_pcw});
    chk("if_id_write", {31'd0, if_id_write}, {31'd0, v.e_pcw});
    e.rw = v.e_rw; e.mr = v.e_mr; e.ctl = v.e_ctl; e.op = v.e_op; e.rd = v.e_rd;
    e.d = v.e_d; e.cnt = v.e_cnt;
    e.rs  = v.fl ? 5'd0 : v.rs;
    e.rt  = v.fl ? 5'd0 : v.rt;
    e.rtd = v.fl ? 32'd0 : (v.d ^ RT_MASK);
    e.imm = v.fl ? 32'd0 : (v.d + 32'd7);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("ID_EX_regWrite", {31'd0, ID_EX_regWrite}, {31'd0, e.rw});
      chk("ID_EX_memRead", {31'd0, ID_EX_memRead}, {31'd0, e.mr});
      chk("ID_EX_ctl", {29'd0, ID_EX_memWrite, ID_EX_memToReg, ID_EX_aluSrc}, {29'd0, e.ctl});
      chk("ID_EX_aluOp", {28'd0, ID_EX_aluOp}, {28'd0, e.op});
      chk("ID_EX_Rs", {27'd0, ID_EX_Rs}, {27'd0, e.rs});
      chk("ID_EX_Rt", {27'd0, ID_EX_Rt}, {27'd0, e.rt});
      chk("ID_EX_Rd", {27'd0, ID_EX_Rd}, {27'd0, e.rd});
      chk("ID_EX_rs_data", ID_EX_rs_data, e.d);
      chk("ID_EX_rt_data", ID_EX_rt_data, e.rtd);
      chk("ID_EX_imm", ID_EX_imm, e.imm);
      chk("stall_count", {16'd0, stall_count}, {16'd0, e.cnt});
    end
  endtask

  initial begin
    // rs rt rd | uses br rw mr rdst | ctl op data | exrd exmr fl || pcw rw mr ctl op rd data cnt
    vecs[0]  = '{5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 4'd0, 32'h100, 5'd0, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b1, 3'b011, 4'd0, 5'd2, 32'h100, 16'd0};   // lw $2
    vecs[1]  = '{5'd2, 5'd4, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 4'd2, 32'h11, 5'd0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 3'b000, 4'd0, 5'd3, 32'h11, 16'd1};    // add $3,$2,$4: stall
    vecs[2]  = '{5'd2, 5'd4, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 4'd2, 32'h11, 5'd2, 1'b1, 1'b0,
                 1'b1, 1'b1, 1'b0, 3'b000, 4'd2, 5'd3, 32'h11, 16'd1};    // add enters EX
    vecs[3]  = '{5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 4'd0, 32'h200, 5'd3, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b1, 3'b011, 4'd0, 5'd0, 32'h200, 16'd1};   // lw $0
    vecs[4]  = '{5'd0, 5'd4, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 4'd0, 32'h22, 5'd0, 1'b1, 1'b0,
                 1'b1, 1'b1, 1'b0, 3'b000, 4'd0, 5'd3, 32'h22, 16'd1};    // add $3,$0,$4: no stall
    vecs[5]  = '{5'd1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 4'd0, 32'h33, 5'd0, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b0, 3'b000, 4'd0, 5'd2, 32'h33, 16'd1};    // add $2
    vecs[6]  = '{5'd2, 5'd5, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 4'd0, 32'h44, 5'd2, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b0, 3'b000, 4'd0, 5'd3, 32'h44, 16'd1};    // add $3,$2: ALU, no stall
    vecs[7]  = '{5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 4'd0, 32'h100, 5'd3, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b1, 3'b011, 4'd0, 5'd2, 32'h100, 16'd1};   // lw $2
    vecs[8]  = '{5'd2, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 4'd1, 32'h55, 5'd3, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 3'b000, 4'd0, 5'd5, 32'h55, 16'd2};    // beq $2,$5: stall 1
    vecs[9]  = '{5'd2, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 4'd1, 32'h55, 5'd2, 1'b1, 1'b0,
                 1'b0, 1'b0, 1'b0, 3'b000, 4'd0, 5'd5, 32'h55, 16'd3};    // stall 2
    vecs[10] = '{5'd2, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 4'd1, 32'h55, 5'd0, 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b0, 3'b000, 4'd1, 5'd5, 32'h55, 16'd3};    // beq proceeds
    vecs[11] = '{5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 4'd0, 32'h100, 5'd0, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b1, 3'b011, 4'd0, 5'd2, 32'h100, 16'd3};   // lw $2
    vecs[12] = '{5'd2, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 4'd1, 32'h55, 5'd5, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 3'b000, 4'd0, 5'd5, 32'h55, 16'd4};    // beq: stall 1
    vecs[13] = '{5'd2, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 4'd1, 32'h55, 5'd2, 1'b1, 1'b1,
                 1'b1, 1'b0, 1'b0, 3'b000, 4'd0, 5'd0, 32'h0, 16'd4};     // flush during stall 2
    vecs[14] = '{5'd2, 5'd7, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 4'd3, 32'h66, 5'd0, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b0, 3'b000, 4'd3, 5'd6, 32'h66, 16'd4};    // no residual stall
    vecs[15] = '{5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 4'd1, 32'h77, 5'd9, 1'b1, 1'b0,
                 1'b0, 1'b0, 1'b0, 3'b000, 4'd0, 5'd0, 32'h77, 16'd5};    // branch vs load in MEM
    vecs[16] = '{5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 4'd1, 32'h77, 5'd0, 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b0, 3'b000, 4'd1, 5'd0, 32'h77, 16'd5};
    vecs[17] = '{5'd1, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 4'd0, 32'h88, 5'd0, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b1, 3'b011, 4'd0, 5'd4, 32'h88, 16'd5};    // lw $4
    vecs[18] = '{5'd1, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 4'd0, 32'h99, 5'd0, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b0, 3'b001, 4'd0, 5'd4, 32'h99, 16'd5};    // addi: rt not a source
    vecs[19] = '{5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 4'd0, 32'h100, 5'd0, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b1, 3'b011, 4'd0, 5'd2, 32'h100, 16'd5};   // lw $2
    vecs[20] = '{5'd2, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 4'd1, 32'h55, 5'd0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 3'b000, 4'd0, 5'd5, 32'h55, 16'd6};    // beq: stall 1, rem left at 1

    rst_n = 1'b0;
    IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0; IF_ID_Rd = 5'd0;
    id_uses_rt = 1'b0; id_is_branch = 1'b0;
    id_regWrite = 1'b0; id_memRead = 1'b0; id_memWrite = 1'b0;
    id_memToReg = 1'b0; id_aluSrc = 1'b0; id_regDst = 1'b0;
    id_aluOp = 4'd0; id_rs_data = 32'd0; id_rt_data = 32'd0; id_imm = 32'd0;
    EX_MEM_Rd = 5'd0; EX_MEM_memRead = 1'b0; flush = 1'b0;

    #2;
    chk("reset_pc_write", {31'd0, pc_write}, 32'd1);
    chk("reset_regWrite", {31'd0, ID_EX_regWrite}, 32'd0);
    chk("reset_Rd", {27'd0, ID_EX_Rd}, 32'd0);
    chk("reset_stall_count", {16'd0, stall_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
    end

    // asynchronous reset in the middle of the second lw/beq stall cycle
    @(negedge clk);
    EX_MEM_Rd = 5'd0; EX_MEM_memRead = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_stall_count", {16'd0, stall_count}, 32'd0);
    chk("midreset_memRead", {31'd0, ID_EX_memRead}, 32'd0);
    chk("midreset_Rs", {27'd0, ID_EX_Rs}, 32'd0);
    chk("midreset_rs_data", ID_EX_rs_data, 32'd0);
    chk("midreset_pc_write", {31'd0, pc_write}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_pc_write", {31'd0, pc_write}, 32'd1);
    @(posedge clk);
    #1;
    chk("post_reset_Rd", {27'd0, ID_EX_Rd}, 32'd5);
    chk("post_reset_stall_count", {16'd0, stall_count}, 32'd0);

    // branch held against a load in MEM stalls every cycle: drive the counter to saturation
    @(negedge clk);
    IF_ID_Rs = 5'd2; id_uses_rt = 1'b0; id_is_branch = 1'b1;
    EX_MEM_Rd = 5'd2; EX_MEM_memRead = 1'b1;
    #1;
    chk("sat_pc_write", {31'd0, pc_write}, 32'd0);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_count_65534", {16'd0, stall_count}, 32'd65534);
    repeat (4466) @(posedge clk);
    #1;
    chk("sat_count_65535", {16'd0, stall_count}, 32'd65535);
    chk("sat_still_stalling", {31'd0, pc_write}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
